// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// The enum values are the debug encodings driven on the state port.
package seq_pkg;

    localparam int TIMEOUT_CYC_DEF = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_FAULT  = ST_FAULT
    } state_t;

endpackage

// File: rtl/seq_wait_timer.sv
// Counts MEM cycles spent without an ack.
// expired is high during the LIMIT-th such cycle.
module seq_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional memory
// access with timeout, and write-back with a retired-instruction counter.
//
// state  | meaning
// IDLE   | stopped, waiting for en
// FETCH  | requesting an instruction word
// DECODE | latching decoder flags
// EXEC   | one-cycle execute, chooses MEM or WB
// MEM    | data-memory access, bounded by TIMEOUT_CYC
// WB     | register/PC update, instruction retires
// FAULT  | memory timeout, left only through rst
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ins_valid,
    input  logic             mem_ack,
    input  logic             wmem_d,
    input  logic             rmem_d,
    input  logic             wreg_d,
    input  logic             wpc_d,
    input  logic             jmp_d,
    output logic             fetch_req,
    output logic             ir_load,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic             pc_jmp,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    state_t cur, nxt;

    logic f_wmem, f_rmem, f_wreg, f_wpc, f_jmp;
    logic tmr_clr, tmr_inc, tmr_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   if (en) nxt = S_FETCH;
            S_FETCH:  if (ins_valid) nxt = S_DECODE;
            S_DECODE: nxt = S_EXEC;
            S_EXEC:   nxt = (f_wmem || f_rmem) ? S_MEM : S_WB;
            S_MEM: begin
                // ack takes priority over a timeout in the same cycle
                if (mem_ack) begin
                    nxt = S_WB;
                end else if (tmr_expired) begin
                    nxt = S_FAULT;
                end
            end
            S_WB:     nxt = en ? S_FETCH : S_IDLE;
            S_FAULT:  nxt = S_FAULT;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_req = 1'b0;
        ir_load   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        pc_we     = 1'b0;
        pc_jmp    = 1'b0;
        busy      = 1'b1;
        fault     = 1'b0;
        case (cur)
            S_IDLE: busy = 1'b0;
            S_FETCH: begin
                fetch_req = 1'b1;
                ir_load   = ins_valid;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = f_wmem;
            end
            S_WB: begin
                reg_we = f_wreg;
                pc_we  = 1'b1;
                pc_jmp = f_jmp & f_wpc;
            end
            S_FAULT: begin
                busy  = 1'b0;
                fault = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_wmem <= 1'b0;
            f_rmem <= 1'b0;
            f_wreg <= 1'b0;
            f_wpc  <= 1'b0;
            f_jmp  <= 1'b0;
        end else if (cur == S_DECODE) begin
            f_wmem <= wmem_d;
            f_rmem <= rmem_d;
            f_wreg <= wreg_d;
            f_wpc  <= wpc_d;
            f_jmp  <= jmp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (cur == S_WB) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Held clear outside MEM so every MEM visit starts counting from zero.
    assign tmr_clr = (cur != S_MEM);
    assign tmr_inc = (cur == S_MEM) && !mem_ack;

    seq_wait_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    assign state = cur;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
Parameters (name, default, meaning):
REQ-001 TIMEOUT_CYC, 16, maximum MEM-state cycles spent waiting for mem_ack before fault.
REQ-002 CNT_W, 16, width of retired-instruction counter.

Ports (name, direction, width, meaning):
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  run enable; sampled in IDLE and WB.
REQ-006 ins_valid  in  1  instruction memory returns a word this cycle.
REQ-007 mem_ack  in  1  data memory completes the pending access.
REQ-008 wmem_d, rmem_d, wreg_d, wpc_d, jmp_d  in  1 each  decoder flags for the instruction held in IR.
REQ-009 fetch_req  out  1  request instruction word.
REQ-010 ir_load  out  1  load IR from the fetched word.
REQ-011 mem_req  out  1  data-memory access request.
REQ-012 mem_we  out  1  data-memory write strobe; valid only with mem_req.
REQ-013 reg_we  out  1  register-file write enable.
REQ-014 pc_we  out  1  PC update strobe.
REQ-015 pc_jmp  out  1  PC source select: 1 = jump target, 0 = PC+1.
REQ-016 busy  out  1  high in every state except IDLE and FAULT.
REQ-017 fault  out  1  sticky memory-timeout indication.
REQ-018 retired  out  CNT_W  count of completed instructions.
REQ-019 state  out  3  current state encoding, for debug.

Function
REQ-020 States and encodings SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6.
REQ-021 IDLE: all strobes low; en=1 -> FETCH, otherwise stay.
REQ-022 FETCH: fetch_req=1; ir_load=ins_valid in the same cycle; ins_valid=1 -> DECODE, otherwise stay with no timeout.
REQ-023 DECODE: latch wmem_d, rmem_d, wreg_d, wpc_d, jmp_d into flag registers; -> EXEC unconditionally.
REQ-024 EXEC: one cycle; latched wmem or rmem -> MEM, otherwise -> WB.
REQ-025 MEM: mem_req=1; mem_we=latched wmem; if both wmem and rmem are latched, the access is a write.
REQ-026 MEM wait counter SHALL clear on MEM entry and increment each MEM cycle without ack.
REQ-027 MEM transitions: mem_ack=1 in any of the first TIMEOUT_CYC MEM cycles -> WB; no ack by the TIMEOUT_CYC-th cycle -> FAULT.
REQ-028 If mem_ack arrives in the same cycle the counter reaches its limit, ack SHALL win (-> WB).
REQ-029 WB: one cycle; reg_we=latched wreg; pc_we=1; pc_jmp=latched jmp AND latched wpc; retired increments by 1, modulo 2^CNT_W.
REQ-030 WB exit: en=1 -> FETCH, else -> IDLE.
REQ-031 en deassertion outside IDLE/WB SHALL NOT abort; the current instruction completes.
REQ-032 FAULT: all strobes low, fault=1, busy=0; exit only via rst.
REQ-033 Latency: a non-memory instruction with ins_valid in the first FETCH cycle SHALL take 4 cycles (FETCH, DECODE, EXEC, WB).
REQ-034 Latency: a memory instruction with mem_ack in the first MEM cycle SHALL take 5 cycles.
REQ-035 Strobe outputs SHALL be decoded from registered state; ir_load and the state exits are the only paths dependent on same-cycle inputs.

Reset
REQ-036 rst=1 at a clock edge SHALL force IDLE, clear the flag registers, the wait counter and retired, and clear fault.
REQ-037 Reset SHALL take precedence over every other event, including mid-MEM and FAULT.
REQ-038 During and immediately after reset, all outputs SHALL be 0 and state=0.

Structure
REQ-039 A shared package seq_pkg SHALL hold the state enum (3-bit), the default TIMEOUT_CYC, and the state encoding constants.
REQ-040 The wait counter SHALL be a sub-module seq_wait_timer with ports clr, inc and expired.
REQ-041 Total RTL SHALL be 120-400 lines; there SHALL be no other sub-modules.

Verification
REQ-042 Scenario 1: rst, then en=1, ins_valid=1 constantly, all decoder flags 0 -> states 1,2,3,5 repeat; pc_we once every 4 cycles; retired=3 after 12 cycles.
REQ-043 Scenario 2: rmem_d=1, wreg_d=1, mem_ack on the 3rd MEM cycle -> mem_req high for 3 cycles, mem_we=0, reg_we=1 in WB, instruction takes 7 cycles.
REQ-044 Scenario 3: wmem_d=1, mem_ack never -> after 16 MEM cycles state=6 and fault=1; rst clears it to state=0, fault=0.
REQ-045 Scenario 4: mem_ack on the 16th MEM cycle -> WB, no fault.
REQ-046 Scenario 5: jmp_d=1, wpc_d=1 -> pc_jmp=1 with pc_we in WB; en dropped in EXEC -> WB completes, then IDLE, busy=0.
REQ-047 Scenario 6: retired preloaded near 0xFFFF via 65535 instructions -> next WB wraps retired to 0x0000; rst asserted mid-MEM -> IDLE the next cycle, mem_req=0.
